s_mem_arbiter: RTL

- Arbitrates the single-port 256x8 S-memory (ramcore: registered address, q valid one cycle after address) between NUM_REQ requesters, e.g. the arcfour core, a message-decrypt stage and a debug reader.
- Round-robin grant, with an optional lock so a requester keeps the port across a read-read-write-write swap.
- Returns read data to the requester with a per-requester valid strobe.

---
 rtl/s_mem_pkg.sv | 16 +
 rtl/s_mem_arbiter_rr_picker.sv | 26 ++
 rtl/s_mem_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/s_mem_pkg.sv
// Shared defaults and FSM encoding for the S-memory arbiter.
// Pure declarations: no latency, no flow control.
package s_mem_pkg;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/s_mem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin find-first, searching from ptr+1 and wrapping.
// Zero latency; no backpressure (pure function of req and ptr).
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx
);
    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if ((onehot == '0) && req[cand]) begin
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end
endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin arbiter with lock for the single-port S-memory; gnt is same-cycle, rd_valid one cycle later.
// No backpressure: a request simply waits until granted. LOCK_TIMEOUT_EN bounds a lock to LOCK_MAX cycles.
module s_mem_arbiter
    import s_mem_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int ADDR_W   = S_ADDR_W,
    parameter int DATA_W   = S_DATA_W,
    parameter int LOCK_MAX = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             rd_valid,
    output logic [DATA_W-1:0]              rd_data,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    output logic                           mem_wren,
    input  logic [DATA_W-1:0]              mem_q,
    output logic                           lock_err
);
    localparam int IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 8 || LOCK_MAX < 1) begin : g_bad_param
        $error("s_mem_arbiter: NUM_REQ must be 1..8 and LOCK_MAX >= 1");
    end

    state_t               state;
    logic [IDX_W-1:0]     owner;
    logic [IDX_W-1:0]     ptr;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic [NUM_REQ-1:0]   gnt_c;
    logic [IDX_W-1:0]     cur_idx;
    logic                 arb_en;
    logic                 pick_any;
    logic                 gnt_any;
    logic                 timeout;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx)
    );

    // Dropping req while locked re-arbitrates in the same cycle; ptr equals the
    // owner while locked, so the search naturally starts just after it.
    assign arb_en   = (state == IDLE) || !req[owner];
    assign pick_any = |pick_oh;
    assign cur_idx  = arb_en ? pick_idx : owner;

    always_comb begin
        gnt_c = '0;
        if (!reset) begin
            if (arb_en) gnt_c = pick_oh;
            else        gnt_c[owner] = 1'b1;
        end
    end

    assign gnt       = gnt_c;
    assign gnt_any   = |gnt_c;
    assign mem_addr  = gnt_any ? req_addr[cur_idx]  : '0;
    assign mem_wdata = gnt_any ? req_wdata[cur_idx] : '0;
    assign mem_wren  = gnt_any & req_we[cur_idx];
    assign rd_data   = mem_q;

`ifdef LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic [CNT_W-1:0] lock_cnt;

    // lock_cnt counts granted locked cycles including the grant that took the lock.
    assign timeout = (state == LOCKED) && req[owner] && req_lock[owner]
                   && (int'(lock_cnt) >= LOCK_MAX - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
        end else if (arb_en && pick_any && req_lock[pick_idx]) begin
            lock_cnt <= CNT_W'(1);
        end else if (!arb_en && req_lock[owner] && !timeout) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign lock_err = timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= '0;
            ptr      <= IDX_W'(NUM_REQ - 1);
            rd_valid <= '0;
        end else begin
            rd_valid <= gnt_c & ~req_we;
            if (arb_en) begin
                if (pick_any) begin
                    ptr   <= pick_idx;
                    owner <= pick_idx;
                    state <= req_lock[pick_idx] ? LOCKED : IDLE;
                end else begin
                    state <= IDLE;
                end
            end else if (!req_lock[owner] || timeout) begin
                state <= IDLE;
            end
        end
    end
endmodule
